// File: rtl/edge_arb_if.sv
// Bundle of edge-event inputs and service-request outputs for edge_arb.
// master = the arbiter, slave = the resource/event side.
interface edge_arb_if #(
  parameter int NCH = 4
) ();
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] setedge;
  logic           ack;
  logic           clrovr;
  logic           req;
  logic [GW-1:0]  grantid;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] overrun;
  logic           tmo;

  modport master (
    input  setedge, ack, clrovr,
    output req, grantid, pending, overrun, tmo
  );

  modport slave (
    output setedge, ack, clrovr,
    input  req, grantid, pending, overrun, tmo
  );
endinterface

// File: rtl/edge_arb.sv
// Latches synchronized rising edges per channel and serves them one at a time
// to a shared resource in round-robin order, with a service timeout.
module edge_arb #(
  parameter int NCH    = 4,
  parameter int TMOW   = 8,
  parameter int TMOVAL = 200
) (
  input  logic       clk,
  input  logic       resetn,
  edge_arb_if.master bus
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  pending_reg, pending_next;
  logic [NCH-1:0]  overrun_reg, overrun_next;
  logic [NCH-1:0]  clr_mask;
  logic [GW-1:0]   grantid_reg, grantid_next;
  logic [GW-1:0]   lastgnt_reg, lastgnt_next;
  logic [GW-1:0]   sel;
  logic [TMOW-1:0] cnt_reg, cnt_next;
  logic            tmo_reg, tmo_next;
  logic            found;
  logic            expire;

  // Two-flop synchronizer plus a detector flop; a rise shows up two edges after capture.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
      logic s1_reg, s2_reg, prev_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          s1_reg   <= bus.setedge[gi];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
        end
      end
      assign rise[gi] = s2_reg & ~prev_reg;
    end
  endgenerate

  // First pending channel strictly after the last one served, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    sel   = lastgnt_reg;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(lastgnt_reg) + k) % NCH;
      if (!found && pending_reg[idx[GW-1:0]]) begin
        found = 1'b1;
        sel   = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    grantid_next = grantid_reg;
    lastgnt_next = lastgnt_reg;
    cnt_next     = cnt_reg;
    tmo_next     = 1'b0;
    clr_mask     = '0;
    expire       = (cnt_reg == TMOW'(TMOVAL - 1));
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next   = BUSY;
          grantid_next = sel;
          cnt_next     = '0;
        end
      end
      BUSY: begin
        if (bus.ack || expire) begin
          clr_mask     = NCH'(1) << grantid_reg;
          lastgnt_next = grantid_reg;
          state_next   = IDLE;
          tmo_next     = ~bus.ack;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A fresh edge beats a clear; overrun only counts edges on bits that stay pending.
    pending_next = (pending_reg & ~clr_mask) | rise;
    overrun_next = (bus.clrovr ? '0 : overrun_reg) | (rise & pending_reg & ~clr_mask);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      grantid_reg <= '0;
      lastgnt_reg <= GW'(NCH - 1);
      cnt_reg     <= '0;
      tmo_reg     <= 1'b0;
      pending_reg <= '0;
      overrun_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grantid_reg <= grantid_next;
      lastgnt_reg <= lastgnt_next;
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.req     = (state_reg == BUSY);
  assign bus.grantid = grantid_reg;
  assign bus.pending = pending_reg;
  assign bus.overrun = overrun_reg;
  assign bus.tmo     = tmo_reg;
endmodule

// File: tb/tb_edge_arb.sv
// Bench for edge_arb: vector table, directed multi-cycle sequences, and a
// randomized run compared against a cycle-level reference model.
module tb_edge_arb;
  localparam int NCH    = 4;
  localparam int TMOVAL = 5;
  localparam int GW     = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  edge_arb_if #(.NCH(NCH)) bus ();

  edge_arb #(.NCH(NCH), .TMOW(8), .TMOVAL(TMOVAL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NCH-1:0] se;
    logic           ack;
    logic           co;
    logic           req;
    logic [GW-1:0]  gid;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovr;
    logic           tmo;
  } vec_t;
  vec_t vecs[10];

  // Reference model: an event is an input sampled high two edges ago after being low three edges ago.
  bit             mdl_on = 1'b0;
  bit [NCH-1:0]   h1, h2, h3;
  bit [NCH-1:0]   m_pend, m_ovr;
  bit             m_busy, m_tmo;
  int             m_gid, m_last, m_cnt;
  int             grants_done = 0;

  function automatic void m_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_ovr = '0;
    m_busy = 1'b0; m_tmo = 1'b0;
    m_gid = 0; m_last = NCH - 1; m_cnt = 0;
  endfunction

  function automatic void m_step(input bit [NCH-1:0] se, input bit a, input bit co);
    bit [NCH-1:0] ev, clr, old_pend;
    bit done, found;
    ev       = h2 & ~h3;
    old_pend = m_pend;
    done     = m_busy && (a || m_cnt == TMOVAL - 1);
    m_tmo    = m_busy && !a && (m_cnt == TMOVAL - 1);
    clr      = done ? (NCH'(1) << m_gid) : '0;
    m_ovr    = (co ? '0 : m_ovr) | (ev & old_pend & ~clr);
    m_pend   = (old_pend & ~clr) | ev;
    if (m_busy) begin
      if (done) begin
        m_busy = 1'b0;
        m_last = m_gid;
        grants_done++;
        $display("rand grant ch%0d finished tmo=%0d at %0t", m_gid, m_tmo, $time);
      end else begin
        m_cnt++;
      end
    end else if (old_pend != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        if (!found && old_pend[(m_last + k) % NCH]) begin
          found = 1'b1;
          m_gid = (m_last + k) % NCH;
        end
      end
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    h3 = h2; h2 = h1; h1 = se;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (mdl_on) m_step(bus.setedge, bus.ack, bus.clrovr);
    #1;
  endtask

  task automatic wait_req(input int max, input string name);
    int n;
    n = 0;
    while (bus.req !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({name, "_req"}, 32'(bus.req), 32'd1);
  endtask

  task automatic ack_once();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    bus.setedge = '0;
    bus.ack     = 1'b0;
    bus.clrovr  = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic chk_all(input string name, input logic r, input logic [GW-1:0] g,
                         input logic [NCH-1:0] p, input logic [NCH-1:0] o, input logic t);
    chk({name, "_req"},  32'(bus.req),     32'(r));
    chk({name, "_gid"},  32'(bus.grantid), 32'(g));
    chk({name, "_pend"}, 32'(bus.pending), 32'(p));
    chk({name, "_ovr"},  32'(bus.overrun), 32'(o));
    chk({name, "_tmo"},  32'(bus.tmo),     32'(t));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ackpct[3];
    bit stop;
    logic [NCH-1:0] se_r;

    //           se     ack   co    req   gid    pend   ovr    tmo
    vecs[0] = '{4'h4, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0};
    vecs[1] = '{4'h4, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0};
    vecs[2] = '{4'h4, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 4'h0, 1'b0};
    vecs[3] = '{4'h4, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 1'b0};
    vecs[4] = '{4'h4, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 1'b0};
    vecs[5] = '{4'h4, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[6] = '{4'h4, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[7] = '{4'h4, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[8] = '{4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0};
    vecs[9] = '{4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 1'b0};

    bus.setedge = '0;
    bus.ack     = 1'b0;
    bus.clrovr  = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_all("reset", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single event on channel 2, then level-high hold and ack in IDLE.
    for (int i = 0; i < 10; i++) begin
      bus.setedge = vecs[i].se;
      bus.ack     = vecs[i].ack;
      bus.clrovr  = vecs[i].co;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].gid, vecs[i].pend, vecs[i].ovr, vecs[i].tmo);
      $display("vec %0d se=%b ack=%b req=%b gid=%0d pend=%b ovr=%b tmo=%b", i, vecs[i].se,
               vecs[i].ack, bus.req, bus.grantid, bus.pending, bus.overrun, bus.tmo);
    end

    // All channels at once, ack on the 2nd busy cycle: grants 0,1,2,3 with an idle cycle between.
    do_reset();
    bus.setedge = 4'hF;
    wait_req(10, "rr_first");
    for (int g = 0; g < NCH; g++) begin
      chk($sformatf("rr%0d_gid", g), 32'(bus.grantid), 32'(g));
      tick();
      chk($sformatf("rr%0d_busy2", g), 32'(bus.req), 32'd1);
      ack_once();
      chk($sformatf("rr%0d_gap", g), 32'(bus.req), 32'd0);
      chk($sformatf("rr%0d_clr", g), 32'(bus.pending[g]), 32'd0);
      if (g < NCH - 1) tick();
      $display("rr grant %0d served", g);
    end
    chk("rr_pend_empty", 32'(bus.pending), 32'd0);

    // Timeout on channel 1, then channel 2 is served.
    bus.setedge = '0;
    repeat (3) tick();
    bus.setedge = 4'h6;
    wait_req(10, "to_first");
    chk("to_gid1", 32'(bus.grantid), 32'd1);
    n = 1;
    while (bus.req === 1'b1 && n < 50) begin
      tick();
      if (bus.req === 1'b1) n++;
    end
    chk("to_req_cycles", 32'(n), 32'(TMOVAL));
    chk("to_pulse", 32'(bus.tmo), 32'd1);
    chk("to_pend", 32'(bus.pending), 32'h4);
    tick();
    chk("to_pulse_end", 32'(bus.tmo), 32'd0);
    chk("to_next_req", 32'(bus.req), 32'd1);
    chk("to_next_gid", 32'(bus.grantid), 32'd2);
    ack_once();
    chk("to_done_pend", 32'(bus.pending), 32'd0);
    $display("timeout sequence done");

    // Overrun on channel 1 while channel 0 is busy; ack coincides with timeout.
    bus.setedge = '0;
    repeat (4) tick();
    bus.setedge = 4'h3;
    wait_req(10, "ovr_first");
    chk("ovr_gid0", 32'(bus.grantid), 32'd0);
    bus.setedge = 4'h1;
    tick();
    bus.setedge = 4'h3;
    n = 0;
    while (bus.overrun[1] !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk("ovr_set", 32'(bus.overrun), 32'h2);
    chk("ovr_pend", 32'(bus.pending), 32'h3);
    chk("ovr_still_busy", 32'(bus.req), 32'd1);
    ack_once();
    chk("ovr_ack_wins_tmo", 32'(bus.tmo), 32'd0);
    chk("ovr_ack_pend", 32'(bus.pending), 32'h2);
    wait_req(5, "ovr_second");
    chk("ovr_gid1", 32'(bus.grantid), 32'd1);
    ack_once();
    chk("ovr_sticky", 32'(bus.overrun), 32'h2);
    bus.clrovr = 1'b1;
    tick();
    bus.clrovr = 1'b0;
    chk("ovr_clear", 32'(bus.overrun), 32'h0);
    $display("overrun sequence done");

    // Edge on granted ch3 in the ack cycle: ch3 stays pending and follows ch0.
    bus.setedge = '0;
    repeat (4) tick();
    bus.setedge = 4'h9;
    wait_req(10, "same_first");
    chk("same_gid3", 32'(bus.grantid), 32'd3);
    bus.setedge = 4'h1;
    tick();
    bus.setedge = 4'h9;
    repeat (2) tick();
    ack_once();
    chk("same_req0", 32'(bus.req), 32'd0);
    chk("same_pend", 32'(bus.pending), 32'h9);
    chk("same_ovr", 32'(bus.overrun), 32'h0);
    wait_req(5, "same_second");
    chk("same_gid0", 32'(bus.grantid), 32'd0);
    ack_once();
    wait_req(5, "same_third");
    chk("same_gid3_again", 32'(bus.grantid), 32'd3);
    ack_once();
    chk("same_pend_empty", 32'(bus.pending), 32'h0);
    $display("set-wins sequence done");

    // Reset during service; held-high input re-detected after release.
    bus.setedge = '0;
    repeat (4) tick();
    bus.setedge = 4'h4;
    wait_req(10, "rst_first");
    chk("rst_gid2", 32'(bus.grantid), 32'd2);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    chk("rst_no_tmo", 32'(bus.tmo), 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    chk("rst_pend_early", 32'(bus.pending), 32'h0);
    chk("rst_no_tmo2", 32'(bus.tmo), 32'd0);
    tick();
    chk("rst_redetect", 32'(bus.pending), 32'h4);
    tick();
    chk("rst_regrant_req", 32'(bus.req), 32'd1);
    chk("rst_regrant_gid", 32'(bus.grantid), 32'd2);
    ack_once();
    $display("reset sequence done");

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    mdl_on = 1'b1;
    ackpct[0] = 40;
    ackpct[1] = 4;
    ackpct[2] = 90;
    stop = 1'b0;
    se_r = '0;
    for (int seg = 0; seg < 3 && !stop; seg++) begin
      for (int c = 0; c < 1000 && !stop; c++) begin
        for (int b = 0; b < NCH; b++)
          if ($urandom_range(5) == 0) se_r[b] = ~se_r[b];
        bus.setedge = se_r;
        bus.ack     = ($urandom_range(99) < 32'(ackpct[seg]));
        bus.clrovr  = ($urandom_range(15) == 0);
        tick();
        chk("rnd_req",  32'(bus.req),     32'(m_busy));
        chk("rnd_gid",  32'(bus.grantid), 32'(m_gid));
        chk("rnd_pend", 32'(bus.pending), 32'(m_pend));
        chk("rnd_ovr",  32'(bus.overrun), 32'(m_ovr));
        chk("rnd_tmo",  32'(bus.tmo),     32'(m_tmo));
        if (errors > 20) stop = 1'b1;
      end
    end
    mdl_on = 1'b0;
    chk("rnd_activity", 32'(grants_done > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
